// File: rtl/multiplier_4_bit_arbiter.sv
// Round-robin arbiter that shares one 4x4 unsigned multiplier between two
// clients. The winner's operands are latched and the registered product is returned via valid/ready.

// Combinational shift-and-add 4x4 unsigned multiplier; product split into nibbles.
module multiplier_4_bit_unsigned_v (
  input  logic [3:0] i_au,
  input  logic [3:0] i_bu,
  output logic [3:0] o_fu0,
  output logic [3:0] o_fu1
);
  logic [7:0] acc;

  always_comb begin
    acc = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (i_bu[i]) acc = acc + ({4'd0, i_au} << i);
    end
  end

  assign o_fu0 = acc[3:0];
  assign o_fu1 = acc[7:4];
endmodule

// Handshake: a request is a level held until o_gnt_<n> pulses. A result is
// offered with o_vld_<n> held high and is consumed on the first edge where
// i_rdy_<n> is sampled high while o_vld_<n> is high.
module multiplier_4_bit_arbiter #(
  parameter bit FIRST_PRIORITY = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_0,
  input  logic       i_req_1,
  input  logic [3:0] i_au_0,
  input  logic [3:0] i_bu_0,
  input  logic [3:0] i_au_1,
  input  logic [3:0] i_bu_1,
  input  logic       i_rdy_0,
  input  logic       i_rdy_1,
  output logic       o_gnt_0,
  output logic       o_gnt_1,
  output logic       o_vld_0,
  output logic       o_vld_1,
  output logic [7:0] o_prod,
  output logic       o_busy,
  output logic [7:0] o_cnt_0,
  output logic [7:0] o_cnt_1,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] vld_q, vld_d;
  logic [7:0] prod_q, prod_d;
  logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic       busy_q, busy_d;
  logic [3:0] fu0, fu1;
  logic       win;
  logic       rdy_owner;

  multiplier_4_bit_unsigned_v u_mul (
    .i_au  (a_q),
    .i_bu  (b_q),
    .o_fu0 (fu0),
    .o_fu1 (fu1)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      owner_q <= 1'b0;
      ptr_q   <= FIRST_PRIORITY;
      gnt_q   <= 2'b00;
      vld_q   <= 2'b00;
      prod_q  <= 8'd0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      prod_q  <= prod_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = 2'b00;
    vld_d     = vld_q;
    prod_d    = prod_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    win       = ptr_q;
    rdy_owner = owner_q ? i_rdy_1 : i_rdy_0;
    unique case (state_q)
      IDLE: begin
        if (i_req_0 || i_req_1) begin
          // Contention goes to the pointer; a lone requester wins outright.
          win        = (i_req_0 && i_req_1) ? ptr_q : i_req_1;
          owner_d    = win;
          a_d        = win ? i_au_1 : i_au_0;
          b_d        = win ? i_bu_1 : i_bu_0;
          gnt_d[win] = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        prod_d         = {fu1, fu0};
        vld_d[owner_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        if (rdy_owner) begin
          vld_d = 2'b00;
          if (owner_q) cnt1_d = cnt1_q + 8'd1;
          else         cnt0_d = cnt0_q + 8'd1;
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign o_gnt_0 = gnt_q[0];
  assign o_gnt_1 = gnt_q[1];
  assign o_vld_0 = vld_q[0];
  assign o_vld_1 = vld_q[1];
  assign o_prod  = prod_q;
  assign o_busy  = busy_q;
  assign o_cnt_0 = cnt0_q;
  assign o_cnt_1 = cnt1_q;
  assign o_state = state_q;
endmodule

// File: tb/tb_multiplier_4_bit_arbiter.sv
// Self-checking bench for multiplier_4_bit_arbiter: directed scenarios then
// randomized traffic, compared cycle by cycle against a transaction-level model.
module tb_multiplier_4_bit_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, rdy0, rdy1;
  logic [3:0] au0, bu0, au1, bu1;
  logic       gnt0, gnt1, vld0, vld1, busy;
  logic [7:0] prod, cnt0, cnt1;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: one in-flight transaction record plus an expected-product queue.
  bit         m_active, m_calc, m_owner, m_ptr;
  bit   [1:0] m_gnt, m_vld;
  logic [7:0] m_prod;
  logic [7:0] m_cnt [2];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  multiplier_4_bit_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req_0 (req0),
    .i_req_1 (req1),
    .i_au_0  (au0),
    .i_bu_0  (bu0),
    .i_au_1  (au1),
    .i_bu_1  (bu1),
    .i_rdy_0 (rdy0),
    .i_rdy_1 (rdy1),
    .o_gnt_0 (gnt0),
    .o_gnt_1 (gnt1),
    .o_vld_0 (vld0),
    .o_vld_1 (vld1),
    .o_prod  (prod),
    .o_busy  (busy),
    .o_cnt_0 (cnt0),
    .o_cnt_1 (cnt1),
    .o_state (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_calc = 0; m_owner = 0; m_ptr = 0;
    m_gnt = 2'b00; m_vld = 2'b00; m_prod = 8'd0;
    m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
    exp_q.delete();
  endtask

  task automatic model_update();
    int w;
    int p;
    m_gnt = 2'b00;
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
        p = (w == 1) ? int'(au1) * int'(bu1) : int'(au0) * int'(bu0);
        exp_q.push_back(8'(p));
        m_owner  = (w == 1);
        m_gnt[w] = 1'b1;
        m_active = 1;
        m_calc   = 1;
      end
    end else if (m_calc) begin
      m_calc = 0;
      if (exp_q.size() > 0) m_prod = exp_q.pop_front();
      m_vld[m_owner] = 1'b1;
    end else if ((m_owner == 1'b0 && rdy0) || (m_owner == 1'b1 && rdy1)) begin
      m_vld = 2'b00;
      m_cnt[m_owner] = m_cnt[m_owner] + 8'd1;
      m_ptr = !m_owner;
      m_active = 0;
    end
  endtask

  task automatic compare();
    chk("gnt0", gnt0, m_gnt[0]);
    chk("gnt1", gnt1, m_gnt[1]);
    chk("vld0", vld0, m_vld[0]);
    chk("vld1", vld1, m_vld[1]);
    chk("prod", prod, m_prod);
    chk("busy", busy, m_active);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("cnt1", cnt1, m_cnt[1]);
    chk("gnt_excl", gnt0 & gnt1, 0);
    chk("vld_excl", vld0 & vld1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; rdy0 = 0; rdy1 = 0;
    au0 = 0; bu0 = 0; au1 = 0; bu1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    chk("rst_prod", prod, 8'h00);
    chk("rst_busy", busy, 0);
    rst_n = 1;

    // Single request with ready already high.
    req0 = 1; au0 = 4'd5; bu0 = 4'd6; rdy0 = 1;
    tick();
    chk("t1_gnt", gnt0, 1);
    req0 = 0; au0 = 4'd0;
    tick();
    chk("t1_prod", prod, 8'h1E);
    chk("t1_vld", vld0, 1);
    tick();
    chk("t1_cnt", cnt0, 8'd1);
    rdy0 = 0;

    // Requester 1 extremes.
    req1 = 1; au1 = 4'd15; bu1 = 4'd15; rdy1 = 1;
    tick();
    req1 = 0;
    tick();
    chk("t2_max", prod, 8'hE1);
    tick();
    req1 = 1; au1 = 4'd15; bu1 = 4'd0;
    tick();
    req1 = 0;
    tick();
    chk("t2_zero", prod, 8'h00);
    tick();
    rdy1 = 0;

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    req0 = 1; au0 = 4'd3; bu0 = 4'd4;
    req1 = 1; au1 = 4'd7; bu1 = 4'd9;
    rdy0 = 1; rdy1 = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k % 3 == 0) begin
        chk("t3_gnt0", gnt0, ((k / 3) % 2 == 0) ? 1 : 0);
        chk("t3_gnt1", gnt1, ((k / 3) % 2 == 1) ? 1 : 0);
      end
      if (k % 3 == 1) chk("t3_prod", prod, ((k / 3) % 2 == 0) ? 8'h0C : 8'h3F);
    end

    // Backpressure on requester 0 while requester 1 waits.
    au0 = 4'd2; bu0 = 4'd3; rdy0 = 0; rdy1 = 0;
    tick();
    chk("t4_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold", prod, 8'h06);
      chk("t4_busy", busy, 1);
      chk("t4_nogrant", gnt1, 0);
    end
    rdy0 = 1;
    tick();
    chk("t4_consumed", vld0, 0);
    tick();
    chk("t4_gnt1", gnt1, 1);
    req1 = 0; rdy1 = 1;
    tick();
    chk("t4_prod1", prod, 8'h3F);
    tick();

    // Operands change after the grant; latched values are used.
    req0 = 1; au0 = 4'd9; bu0 = 4'd9; rdy0 = 1;
    tick();
    req0 = 0; au0 = 4'd1; bu0 = 4'd1;
    tick();
    chk("t5_latched", prod, 8'h51);
    tick();

    // Reset while in CALC.
    req0 = 1; au0 = 4'd7; bu0 = 4'd8; rdy0 = 0;
    tick();
    rst_n = 0;
    #1;
    chk("t6_vld", vld0, 0);
    chk("t6_gnt", gnt0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_prod", prod, 8'h00);
    chk("t6_cnt0", cnt0, 8'd0);
    chk("t6_cnt1", cnt1, 8'd0);
    tick();
    rst_n = 1; rdy0 = 1;
    tick();
    chk("t6_regnt", gnt0, 1);
    req0 = 0;
    tick();
    chk("t6_prod2", prod, 8'h38);
    tick();

    // Back-to-back operations on requester 0 until its count wraps.
    req0 = 1; rdy0 = 1;
    for (int k = 0; k < 255 * 3; k++) begin
      au0 = 4'($urandom_range(0, 15));
      bu0 = 4'($urandom_range(0, 15));
      tick();
    end
    chk("wrap_zero", cnt0, 8'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("wrap_one", cnt0, 8'd1);
    idle_inputs();
    tick();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      req0 = ($urandom_range(0, 9) < 6);
      req1 = ($urandom_range(0, 9) < 6);
      rdy0 = ($urandom_range(0, 1) == 1);
      rdy1 = ($urandom_range(0, 1) == 1);
      au0  = 4'($urandom_range(0, 15));
      bu0  = 4'($urandom_range(0, 15));
      au1  = 4'($urandom_range(0, 15));
      bu1  = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
